// File: rtl/phys_reg_free_list.sv
// Physical-register free list: hands out rename tags at dispatch, reclaims them
// at retire, and rewinds its allocation pointer to a per-ROB-entry checkpoint.
module phys_reg_free_list #(
  parameter int NUM_PR   = 64,
  parameter int NUM_ARCH = 32,
  parameter int NUM_ROB  = 8,
  localparam int PR_W    = $clog2(NUM_PR),
  localparam int FL_SIZE = NUM_PR - NUM_ARCH,
  localparam int FL_IW   = $clog2(FL_SIZE),
  localparam int FL_W    = FL_IW + 1,
  localparam int ROB_W   = $clog2(NUM_ROB)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dispatch_req,
  input  logic [ROB_W-1:0] ROB_tail_idx,
  output logic             dispatch_grant,
  output logic [PR_W-1:0]  T_idx,
  input  logic             retire_en,
  input  logic [PR_W-1:0]  Told_idx,
  input  logic             rollback_en,
  input  logic [ROB_W-1:0] ROB_rollback_idx,
  output logic [FL_W-1:0]  free_count,
  output logic             empty
);

  logic [PR_W-1:0] list_q [FL_SIZE];
  logic [FL_W-1:0] head_q;
  logic [FL_W-1:0] tail_q;
  logic [FL_W-1:0] ckpt_q [NUM_ROB];

  logic [FL_W-1:0] head_inc;
  logic            full;
  logic            retire_ok;

  // Pointer difference is exact because the wrap bit distinguishes full from empty.
  assign free_count = tail_q - head_q;
  assign empty      = (free_count == '0);
  assign full       = (free_count == FL_W'(FL_SIZE));
  assign head_inc   = head_q + 1'b1;
  assign T_idx      = list_q[head_q[FL_IW-1:0]];

  // Request/grant: dispatch_req may be held for any number of cycles; a tag is
  // consumed exactly in a cycle where dispatch_grant is high, and T_idx in that
  // same cycle is the tag taken. Rollback and reset always win over dispatch.
  assign dispatch_grant = en & dispatch_req & ~empty & ~rollback_en & ~reset;

  // Retiring into a full list is an upstream bug; it is dropped rather than corrupting tail.
  assign retire_ok = en & retire_en & ~full;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        list_q[i] <= PR_W'(NUM_ARCH + i);
      end
      for (int r = 0; r < NUM_ROB; r++) begin
        ckpt_q[r] <= '0;
      end
      head_q <= '0;
      tail_q <= FL_W'(FL_SIZE);
    end else if (en) begin
      if (rollback_en) begin
        head_q <= ckpt_q[ROB_rollback_idx];
      end else if (dispatch_grant) begin
        head_q               <= head_inc;
        ckpt_q[ROB_tail_idx] <= head_inc;
      end
      if (retire_ok) begin
        list_q[tail_q[FL_IW-1:0]] <= Told_idx;
        tail_q                    <= tail_q + 1'b1;
      end
    end
  end

  a_no_retire_when_full: assert property (
    @(posedge clock) disable iff (reset) !(en && retire_en && full));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed vector table, hand-written corner
// sequences, then random traffic against a counter-based reference model.
module tb_phys_reg_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       dispatch_req;
  logic [2:0] ROB_tail_idx;
  logic       dispatch_grant;
  logic [5:0] T_idx;
  logic       retire_en;
  logic [5:0] Told_idx;
  logic       rollback_en;
  logic [2:0] ROB_rollback_idx;
  logic [5:0] free_count;
  logic       empty;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  phys_reg_free_list dut (
    .clock(clock), .reset(reset), .en(en), .dispatch_req(dispatch_req),
    .ROB_tail_idx(ROB_tail_idx), .dispatch_grant(dispatch_grant), .T_idx(T_idx),
    .retire_en(retire_en), .Told_idx(Told_idx), .rollback_en(rollback_en),
    .ROB_rollback_idx(ROB_rollback_idx), .free_count(free_count), .empty(empty)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       req;
    logic [2:0] tidx;
    logic       ret;
    logic [5:0] told;
    logic       rb;
    logic [2:0] rbi;
    logic       exp_grant;
    logic [5:0] exp_t;
    logic [5:0] exp_free;
    logic       exp_empty;
  } vec_t;

  function automatic vec_t mk(logic rst, logic e, logic req, int tidx, logic ret, int told,
                              logic rb, int rbi, logic g, int t, int f, logic emp);
    vec_t v;
    v.rst = rst; v.en = e; v.req = req; v.tidx = 3'(tidx);
    v.ret = ret; v.told = 6'(told); v.rb = rb; v.rbi = 3'(rbi);
    v.exp_grant = g; v.exp_t = 6'(t); v.exp_free = 6'(f); v.exp_empty = emp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs before the rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    reset = v.rst; en = v.en; dispatch_req = v.req; ROB_tail_idx = v.tidx;
    retire_en = v.ret; Told_idx = v.told; rollback_en = v.rb; ROB_rollback_idx = v.rbi;
    #1;
    check({tag, ".grant"}, 32'(dispatch_grant), 32'(v.exp_grant));
    check({tag, ".free"},  32'(free_count),     32'(v.exp_free));
    check({tag, ".empty"}, 32'(empty),          32'(v.exp_empty));
    if (!v.exp_empty) check({tag, ".t_idx"}, 32'(T_idx), 32'(v.exp_t));
  endtask

  task automatic do_reset();
    vec_t v;
    v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1; en = 1'b1; dispatch_req = 1'b0; ROB_tail_idx = '0;
    retire_en = 1'b0; Told_idx = '0; rollback_en = 1'b0; ROB_rollback_idx = '0;
    @(negedge clock);
    #1;
    check("reset.grant_low", 32'(dispatch_grant), 32'(v.exp_grant));
  endtask

  vec_t tbl[14];

  // Reference model: unbounded allocation/free counters; a tag's list slot is its position mod 32.
  int alloc_n, free_n;
  int ck[8];
  int mem[32];

  task automatic model_reset();
    alloc_n = 0; free_n = 32;
    for (int i = 0; i < 8; i++) ck[i] = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32 + i;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dispatch_req = 1'b0; ROB_tail_idx = '0;
    retire_en = 1'b0; Told_idx = '0; rollback_en = 1'b0; ROB_rollback_idx = '0;

    // Rollback scenarios and en=0 hold, written as cycle-by-cycle vectors.
    //              rst en req tidx ret told rb rbi  g   t   f  emp
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 32, 32, 0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 33, 31, 0);
    tbl[2]  = mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 34, 30, 0);
    tbl[3]  = mk(0, 1, 1, 3, 0, 0, 0, 0, 1, 35, 29, 0);
    tbl[4]  = mk(0, 1, 1, 4, 0, 0, 1, 1, 0, 36, 28, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 34, 30, 0);
    tbl[6]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 34, 30, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 32, 32, 0);
    tbl[8]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 33, 31, 0);
    tbl[9]  = mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 34, 30, 0);
    tbl[10] = mk(0, 1, 0, 0, 1, 7, 1, 0, 0, 35, 29, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 33, 32, 0);
    tbl[12] = mk(0, 0, 1, 5, 1, 9, 0, 0, 0, 33, 32, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 33, 32, 0);

    // Reset, then idle.
    do_reset();
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 32, 32, 0), "idle");

    // Drain all 32 tags, ROB index cycling 0..7.
    for (int i = 0; i < 32; i++)
      apply(mk(0, 1, 1, i % 8, 0, 0, 0, 0, 1, 32 + i, 32 - i, 0), $sformatf("drain%0d", i));
    apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "req_on_empty");
    apply(mk(0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1), "retire5_from_empty");
    apply(mk(0, 1, 1, 0, 1, 9, 0, 0, 1, 5, 1, 0), "disp_and_retire9");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0), "after_disp_retire");

    // Reset mid-stream restores the idle picture.
    do_reset();
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 32, 32, 0), "post_reset_idle");

    // Vector table.
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      int cnt, r;
      cnt = free_n - alloc_n;
      v.rst  = 1'b0;
      v.en   = ($urandom_range(0, 9) != 0);
      v.req  = 1'($urandom_range(0, 1));
      v.tidx = 3'($urandom_range(0, 7));
      v.ret  = (cnt < 32) && ($urandom_range(0, 9) < 4);
      v.told = 6'($urandom_range(0, 63));
      v.rbi  = 3'($urandom_range(0, 7));
      r = v.ret ? 1 : 0;
      v.rb   = ($urandom_range(0, 7) == 0) && (free_n - ck[v.rbi] >= 0) &&
               (free_n + r - ck[v.rbi] <= 32);
      v.exp_grant = v.en && v.req && (cnt != 0) && !v.rb;
      v.exp_free  = 6'(cnt);
      v.exp_empty = (cnt == 0);
      v.exp_t     = 6'(mem[alloc_n % 32]);
      apply(v, "rand");
      if (v.en) begin
        if (v.rb) alloc_n = ck[v.rbi];
        else if (v.exp_grant) begin
          alloc_n++;
          ck[v.tidx] = alloc_n;
        end
        if (v.ret) begin
          mem[free_n % 32] = int'(v.told);
          free_n++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
